// File: rtl/shift_unit_pkg.sv
// Shared op codes and level-to-stage mapping for the pipelined shifter.
// SHIFT_UNIT_ROTATE_EN enables the ROR/ROL op codes.
package shift_unit_pkg;

    localparam int SH_OP_W = 3;

    localparam logic [SH_OP_W-1:0] SH_OP_SRL = 3'b000;
    localparam logic [SH_OP_W-1:0] SH_OP_SLL = 3'b001;
    localparam logic [SH_OP_W-1:0] SH_OP_SRA = 3'b010;
    localparam logic [SH_OP_W-1:0] SH_OP_ROR = 3'b011;
    localparam logic [SH_OP_W-1:0] SH_OP_ROL = 3'b100;

    function automatic int lvl_lo(input int s, input int l, input int st);
        return s * l / st;
    endfunction

    // The last stage absorbs any remainder levels.
    function automatic int lvl_hi(input int s, input int l, input int st);
        return (s == st - 1) ? l - 1 : (s + 1) * l / st - 1;
    endfunction

    function automatic logic op_left(input logic [SH_OP_W-1:0] op);
        return (op == SH_OP_SLL) || (op == SH_OP_ROL);
    endfunction

    function automatic logic op_rot(input logic [SH_OP_W-1:0] op);
        return (op == SH_OP_ROR) || (op == SH_OP_ROL);
    endfunction

    function automatic logic op_legal(input logic [SH_OP_W-1:0] op);
`ifdef SHIFT_UNIT_ROTATE_EN
        return op <= SH_OP_ROL;
`else
        return op <= SH_OP_SRA;
`endif
    endfunction

endpackage

// File: rtl/shift_unit_pipe_group.sv
// Combinational right-shift over the barrel levels owned by one stage.
// SHIFT_UNIT_ROTATE_EN adds the wrap-around path for rotates.
module shift_level_group
    import shift_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LVL_LO = 0,
    parameter int LVL_HI = 0
) (
    input  logic [XLEN-1:0]          i_data,
    input  logic [LVL_HI-LVL_LO:0]   i_shamt,
    input  logic [SH_OP_W-1:0]       i_op,
    output logic [XLEN-1:0]          o_data
);

    logic [XLEN-1:0] w_d;
    logic [XLEN-1:0] w_t;

    always_comb begin
        w_d = i_data;
        w_t = '0;
        for (int k = LVL_LO; k <= LVL_HI; k++) begin
            if (i_shamt[k-LVL_LO]) begin
                w_t = w_d >> (1 << k);
                if (i_op == SH_OP_SRA && w_d[XLEN-1])
                    w_t = w_t | ~({XLEN{1'b1}} >> (1 << k));
`ifdef SHIFT_UNIT_ROTATE_EN
                if (op_rot(i_op))
                    w_t = w_t | (w_d << (XLEN - (1 << k)));
`endif
                w_d = w_t;
            end
        end
        o_data = w_d;
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with valid/ready handshake, flush and tag.
// SHIFT_UNIT_ROTATE_EN enables ROR/ROL; otherwise those codes yield 0.
module shift_unit_pipe
    import shift_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_data,
    input  logic [$clog2(XLEN)-1:0]  in_shamt,
    input  logic [SH_OP_W-1:0]       in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(XLEN);
    localparam int LST = STAGES - 1;

    logic [STAGES-1:0]  r_v;
    logic [STAGES-1:0]  w_rdy;
    logic [STAGES-1:0]  w_vin;
    logic [XLEN-1:0]    r_data [STAGES];
    logic [XLEN-1:0]    w_din  [STAGES];
    logic [XLEN-1:0]    w_dout [STAGES];
    logic [SH_OP_W-1:0] r_op   [STAGES];
    logic [SH_OP_W-1:0] w_opin [STAGES];
    logic [TAG_W-1:0]   r_tag  [STAGES];
    logic [TAG_W-1:0]   w_tagin[STAGES];
    logic [XLEN-1:0]    w_rev_in;
    logic [XLEN-1:0]    w_rev_out;
    logic [XLEN-1:0]    w_prep;

    always_comb begin
        w_rev_in  = '0;
        w_rev_out = '0;
        for (int i = 0; i < XLEN; i++) begin
            w_rev_in[i]  = in_data[XLEN-1-i];
            w_rev_out[i] = r_data[LST][XLEN-1-i];
        end
    end

    // Undefined ops enter as zero so every later level produces 0.
    assign w_prep = !op_legal(in_op) ? '0 :
                    op_left(in_op)   ? w_rev_in : in_data;

    assign in_ready  = w_rdy[0] && !flush;
    assign out_valid = r_v[LST];
    assign out_tag   = r_tag[LST];
    assign out_data  = op_left(r_op[LST]) ? w_rev_out : r_data[LST];

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int LO = lvl_lo(s, SHW, STAGES);
        localparam int HI = lvl_hi(s, SHW, STAGES);

        logic [SHW-1-LO:0] w_rem;

        // A stage can load when it or any stage below it has a hole.
        assign w_rdy[s] = out_ready || !(&r_v[LST:s]);

        if (s == 0) begin : g_first
            assign w_rem      = in_shamt;
            assign w_din[s]   = w_prep;
            assign w_opin[s]  = in_op;
            assign w_tagin[s] = in_tag;
            assign w_vin[s]   = in_valid && in_ready;
        end else begin : g_next
            assign w_rem      = g_st[s-1].g_sh.r_sh;
            assign w_din[s]   = r_data[s-1];
            assign w_opin[s]  = r_op[s-1];
            assign w_tagin[s] = r_tag[s-1];
            assign w_vin[s]   = r_v[s-1];
        end

        if (s < LST) begin : g_sh
            logic [SHW-2-HI:0] r_sh;
            always_ff @(posedge clk) begin
                if (rst)
                    r_sh <= '0;
                else if (w_rdy[s] && w_vin[s])
                    r_sh <= w_rem[SHW-1-LO:HI-LO+1];
            end
        end

        shift_level_group #(
            .XLEN   (XLEN),
            .LVL_LO (LO),
            .LVL_HI (HI)
        ) u_grp (
            .i_data  (w_din[s]),
            .i_shamt (w_rem[HI-LO:0]),
            .i_op    (w_opin[s]),
            .o_data  (w_dout[s])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
                r_op[s]   <= '0;
                r_tag[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (flush)
                    r_v[s] <= 1'b0;
                else if (w_rdy[s])
                    r_v[s] <= w_vin[s];
                if (w_rdy[s] && w_vin[s]) begin
                    r_data[s] <= w_dout[s];
                    r_op[s]   <= w_opin[s];
                    r_tag[s]  <= w_tagin[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe against an arithmetic reference.
// Honours SHIFT_UNIT_ROTATE_EN for rotate expectations.
module tb_shift_unit_pipe;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
`ifdef SHIFT_UNIT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_data;
    logic [4:0]       in_shamt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;

    int nvec = 0;
    int nerr = 0;

    shift_unit_pipe #(
        .XLEN   (XLEN),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                              input int sh,
                                              input logic [2:0] op);
        case (op)
            3'd0: return d >> sh;
            3'd1: return d << sh;
            3'd2: return $unsigned($signed(d) >>> sh);
            3'd3: return ROT ? ((d >> sh) | (d << (32 - sh))) : 32'h0;
            3'd4: return ROT ? ((d << sh) | (d >> (32 - sh))) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] d;
        int          sh;
        logic [2:0]  op;
        logic [31:0] e;
    } vec_t;

    vec_t tv[13] = '{
        '{32'h8000_00F0, 4,  3'd0, 32'h0800_000F},
        '{32'h8000_00F0, 4,  3'd1, 32'h0000_0F00},
        '{32'h8000_00F0, 4,  3'd2, 32'hF800_000F},
        '{32'hA5A5_A5A5, 0,  3'd0, 32'hA5A5_A5A5},
        '{32'hA5A5_A5A5, 0,  3'd1, 32'hA5A5_A5A5},
        '{32'hA5A5_A5A5, 0,  3'd2, 32'hA5A5_A5A5},
        '{32'hA5A5_A5A5, 31, 3'd2, 32'hFFFF_FFFF},
        '{32'hA5A5_A5A5, 31, 3'd0, 32'h0000_0001},
        '{32'hA5A5_A5A5, 31, 3'd1, 32'h8000_0000},
        '{32'h0000_0001, 1,  3'd3, ROT ? 32'h8000_0000 : 32'h0},
        '{32'hF000_0000, 4,  3'd4, ROT ? 32'h0000_000F : 32'h0},
        '{32'hA5A5_A5A5, 0,  3'd3, ROT ? 32'hA5A5_A5A5 : 32'h0},
        '{32'hA5A5_A5A5, 5,  3'd7, 32'h0}
    };

    task automatic run_op(input logic [31:0] d, input logic [4:0] sh,
                          input logic [2:0] op, input logic [4:0] tag,
                          output logic [31:0] res, output logic [4:0] rtag,
                          output int lat, output bit ok);
        bit acc;
        ok = 0; lat = 0; acc = 0; res = '0; rtag = '0;
        in_valid = 1; in_data = d; in_shamt = sh; in_op = op; in_tag = tag;
        out_ready = 1;
        #1;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 0;
        if (!acc) return;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid) begin
            ok = 1; res = out_data; rtag = out_tag;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1; flush = 0; in_valid = 0; out_ready = 1;
        in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1; rst = 0; #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        nvec++;
        if (out_data !== 32'h0 || out_tag !== 5'h0) begin
            nerr++; $display("FAIL reset_out_data got %h/%h want 0/0", out_data, out_tag);
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        bit          ok;
        for (int i = 0; i < 13; i++) begin
            run_op(tv[i].d, 5'(tv[i].sh), tv[i].op, 5'(i), res, rtag, lat, ok);
            nvec++;
            if (!ok) begin
                nerr++; $display("FAIL directed_%0d_timeout no result", i);
                continue;
            end
            if (res !== tv[i].e) begin
                nerr++; $display("FAIL directed_%0d_data got %h want %h", i, res, tv[i].e);
            end
            nvec++;
            if (rtag !== 5'(i)) begin
                nerr++; $display("FAIL directed_%0d_tag got %0d want %0d", i, rtag, i);
            end
            nvec++;
            if (lat != STAGES - 1) begin
                nerr++; $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, STAGES - 1);
            end
        end
    endtask

    task automatic test_stream(input int n, input bit rnd);
        logic [36:0] q[$];
        logic [36:0] e;
        logic [31:0] hd;
        logic [4:0]  ht;
        bit          held;
        int          sent, got;
        sent = 0; got = 0; held = 0; hd = '0; ht = '0;
        for (int cyc = 0; cyc < 40 * n && got < n; cyc++) begin
            in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_op     = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom_range(0, 31));
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 4 && cyc < 7);
            #1;
            if (held) begin
                nvec++;
                if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
                    nerr++;
                    $display("FAIL stall_hold got %0b/%h/%h want 1/%h/%h",
                             out_valid, out_data, out_tag, hd, ht);
                end
            end
            if (!rnd && cyc < 4) begin
                nvec++;
                if (in_ready !== 1'b1) begin
                    nerr++; $display("FAIL throughput cyc %0d in_ready got 0 want 1", cyc);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({ref_shift(in_data, int'(in_shamt), in_op), in_tag});
                sent++;
            end
            if (out_valid && out_ready) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++; $display("FAIL stream_extra got %h want none", out_data);
                end else begin
                    e = q.pop_front();
                    if ({out_data, out_tag} !== e) begin
                        nerr++;
                        $display("FAIL stream_%0d got %h/%h want %h/%h",
                                 got, out_data, out_tag, e[36:5], e[4:0]);
                    end
                end
                got++;
            end
            held = out_valid && !out_ready;
            hd = out_data; ht = out_tag;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        nvec++;
        if (got != n) begin
            nerr++; $display("FAIL stream_count got %0d want %0d", got, n);
        end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        bit          ok;
        out_ready = 0;
        for (int i = 0; i < STAGES; i++) begin
            in_valid = 1; in_data = $urandom; in_shamt = 5'(i + 1);
            in_op = 3'd0; in_tag = 5'(i + 20);
            #1;
            nvec++;
            if (in_ready !== 1'b1) begin
                nerr++; $display("FAIL flush_fill_%0d in_ready got 0 want 1", i);
            end
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 1; out_ready = 1;
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++; $display("FAIL flush_in_ready got %0b want 0", in_ready);
        end
        @(posedge clk); #1;
        flush = 0;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (out_valid !== 1'b0) begin
                nerr++; $display("FAIL flush_drop cyc %0d out_valid got 1 want 0", i);
            end
            @(posedge clk); #1;
        end
        run_op(32'h1234_5678, 5'd8, 3'd0, 5'h1B, res, rtag, lat, ok);
        nvec++;
        if (!ok || res !== 32'h0012_3456 || rtag !== 5'h1B) begin
            nerr++; $display("FAIL flush_next got %0b/%h/%h want 1/00123456/1b", ok, res, rtag);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        bit          ok;
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd3;
            in_op = 3'd2; in_tag = 5'(i + 7);
            @(posedge clk); #1;
        end
        rst = 1; flush = 1;
        @(posedge clk); #1;
        nvec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0) begin
            nerr++;
            $display("FAIL rst_mid got %0b/%h/%h want 0/0/0", out_valid, out_data, out_tag);
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL rst_mid_ready got %0b want 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (out_valid !== 1'b0) begin
                nerr++; $display("FAIL rst_mid_ghost cyc %0d got 1 want 0", i);
            end
            @(posedge clk); #1;
        end
        run_op(32'hFFFF_FFFF, 5'd1, 3'd7, 5'h11, res, rtag, lat, ok);
        nvec++;
        if (!ok || res !== 32'h0 || rtag !== 5'h11) begin
            nerr++; $display("FAIL op111 got %0b/%h/%h want 1/0/11", ok, res, rtag);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stream(8, 1'b0);
        test_flush;
        test_reset_mid;
        test_stream(200, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
